// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared state encoding, instruction field constants and datapath
// select encodings for the multicycle controller.
package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEM_ADDR,
        MEM_READ,
        MEM_WB,
        MEM_WRITE,
        EXEC_R,
        R_WB,
        BRANCH,
        JUMP,
        ADDI_EXEC,
        ADDI_WB
    } state_t;

    // Opcode field values (instruction[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // Funct field values (instruction[5:0]) for R-type
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU operation encodings
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    // ALU B operand select encodings
    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // PC source select encodings
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps the R-type Funct field to an ALU operation and flags
// unsupported Funct values. Purely combinational.
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [5:0] i_funct,
    output logic [2:0] o_alu_op,
    output logic       o_valid
);

    // Funct lookup; unknown codes fall back to add and are reported invalid
    always_comb begin
        o_alu_op = ALU_ADD;
        o_valid  = 1'b1;
        case (i_funct)
            FN_ADD:  o_alu_op = ALU_ADD;
            FN_SUB:  o_alu_op = ALU_SUB;
            FN_AND:  o_alu_op = ALU_AND;
            FN_OR:   o_alu_op = ALU_OR;
            FN_SLT:  o_alu_op = ALU_SLT;
            default: begin
                o_alu_op = ALU_ADD;
                o_valid  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: state-sequenced control unit for a multicycle
// MIPS-style datapath (lw, sw, R-type, addi, beq, j).
// Optional feature: define CTRL_BNE_EN to also execute bne (Opcode 000101)
// through the BRANCH state with the Zero test inverted; when undefined that
// opcode is treated as illegal.
module multicycle_controller
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemToReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic       IllegalOp
);

    state_t     r_state;
    state_t     w_next_state;
    state_t     w_dispatch;
    logic       w_illegal;
    logic       w_branch_taken;
    logic [2:0] w_r_alu_op;
    logic       w_r_valid;

    alu_decoder u_alu_decoder (
        .i_funct  (Funct),
        .o_alu_op (w_r_alu_op),
        .o_valid  (w_r_valid)
    );

    // Opcode dispatch target out of DECODE, and whether the opcode is unsupported
    always_comb begin
        w_dispatch = FETCH;
        w_illegal  = 1'b0;
        case (Opcode)
            OP_RTYPE:      w_dispatch = EXEC_R;
            OP_LW, OP_SW:  w_dispatch = MEM_ADDR;
            OP_BEQ:        w_dispatch = BRANCH;
`ifdef CTRL_BNE_EN
            OP_BNE:        w_dispatch = BRANCH;
`endif
            OP_J:          w_dispatch = JUMP;
            OP_ADDI:       w_dispatch = ADDI_EXEC;
            default: begin
                w_dispatch = FETCH;
                w_illegal  = 1'b1;
            end
        endcase
    end

    // Branch condition: beq takes on Zero, bne (when enabled) on ~Zero
`ifdef CTRL_BNE_EN
    assign w_branch_taken = (Opcode == OP_BNE) ? ~Zero : Zero;
`else
    assign w_branch_taken = Zero;
`endif

    // State register with synchronous reset back to FETCH
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; FETCH and memory states stall until MemReady
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            FETCH:     w_next_state = MemReady ? DECODE : FETCH;
            DECODE:    w_next_state = w_dispatch;
            MEM_ADDR:  w_next_state = (Opcode == OP_LW) ? MEM_READ : MEM_WRITE;
            MEM_READ:  w_next_state = MemReady ? MEM_WB : MEM_READ;
            MEM_WB:    w_next_state = FETCH;
            MEM_WRITE: w_next_state = MemReady ? FETCH : MEM_WRITE;
            EXEC_R:    w_next_state = R_WB;
            R_WB:      w_next_state = FETCH;
            BRANCH:    w_next_state = FETCH;
            JUMP:      w_next_state = FETCH;
            ADDI_EXEC: w_next_state = ADDI_WB;
            ADDI_WB:   w_next_state = FETCH;
            default:   w_next_state = FETCH;
        endcase
    end

    // Output decode from current state; everything held low while rst is high
    always_comb begin
        PCWrite   = 1'b0;
        IorD      = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        MemToReg  = 1'b0;
        RegDst    = 1'b0;
        RegWrite  = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = SRCB_RT;
        ALUOp     = ALU_ADD;
        PCSrc     = PCSRC_ALU;
        IllegalOp = 1'b0;
        if (!rst) begin
            case (r_state)
                FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = SRCB_FOUR;
                    IRWrite = MemReady;
                    PCWrite = MemReady;
                end
                DECODE: begin
                    ALUSrcB   = SRCB_IMM_SH2;
                    IllegalOp = w_illegal;
                end
                MEM_ADDR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                end
                MEM_READ: begin
                    IorD    = 1'b1;
                    MemRead = 1'b1;
                end
                MEM_WB: begin
                    MemToReg = 1'b1;
                    RegWrite = 1'b1;
                end
                MEM_WRITE: begin
                    IorD     = 1'b1;
                    MemWrite = 1'b1;
                end
                EXEC_R: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = w_r_alu_op;
                end
                R_WB: begin
                    RegDst   = 1'b1;
                    RegWrite = w_r_valid;
                end
                BRANCH: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = ALU_SUB;
                    PCSrc   = PCSRC_ALUOUT;
                    PCWrite = w_branch_taken;
                end
                JUMP: begin
                    PCSrc   = PCSRC_JUMP;
                    PCWrite = 1'b1;
                end
                ADDI_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                end
                ADDI_WB: begin
                    RegWrite = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
